// File: rtl/iob_fifo2axis_buf.sv
// Two-entry circular buffer between the FIFO read port and the stream output.
// The head word is always presented on rdata; occ reports 0..2 stored words.
module iob_fifo2axis_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem [2];
  logic              wptr;
  logic              rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr) begin
        mem[wptr] <= wdata;
        wptr      <= ~wptr;
      end
      if (rd) rptr <= ~rptr;
      occ <= occ + {1'b0, wr} - {1'b0, rd};
    end
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/iob_fifo2axis.sv
// Drains a one-cycle-latency FIFO read port into a valid/ready stream,
// framing beats into packets of len beats with m_tlast on the final beat.
module iob_fifo2axis #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [LEN_W-1:0]  len,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy
);

  logic             act;
  logic             inflight;
  logic [1:0]       occ;
  logic             pop;
  logic [2:0]       slots_used;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;

  iob_fifo2axis_buf #(.DATA_W(DATA_W)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (inflight),
    .wdata (fifo_rdata),
    .rd    (pop),
    .rdata (m_tdata),
    .occ   (occ)
  );

  assign pop        = m_tvalid & m_tready;
  // pop implies occ >= 1, so this never underflows
  assign slots_used = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  // act keeps fifo_rd low until the first edge after reset release
  assign fifo_rd    = act & en & ~fifo_empty & (slots_used < 3'd2);
  assign m_tvalid   = (occ != 2'd0);
  assign m_tlast    = m_tvalid & (len_q != '0) & (cnt == len_q - LEN_W'(1));
  assign busy       = (occ != 2'd0) | inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act      <= 1'b0;
      inflight <= 1'b0;
      len_q    <= '0;
      cnt      <= '0;
    end else begin
      act      <= 1'b1;
      inflight <= fifo_rd;
      // packet length only changes on a packet boundary
      if (cnt == '0) len_q <= len;
      if (pop) cnt <= m_tlast ? '0 : cnt + LEN_W'(1);
    end
  end

endmodule
